// File: rtl/led_matrix_pwm_scanner_if.sv
// Frame-load bus between the render logic (master) and the LED matrix scanner (slave).
// Carries the next-frame level arrays and the FrameLoad/FrameAck handshake.
interface led_matrix_pwm_scanner_if #(
    parameter int unsigned ROWS  = 16,
    parameter int unsigned COLS  = 16,
    parameter int unsigned DEPTH = 2
);
    logic [ROWS-1:0][COLS-1:0][DEPTH-1:0] RedLevel;
    logic [ROWS-1:0][COLS-1:0][DEPTH-1:0] GrnLevel;
    logic                                 FrameLoad;
    logic                                 FrameAck;

    modport master (output RedLevel, output GrnLevel, output FrameLoad, input FrameAck);
    modport slave  (input RedLevel, input GrnLevel, input FrameLoad, output FrameAck);
endinterface

// File: rtl/led_matrix_pwm_scanner.sv
// Row-scanned two-colour LED matrix driver with per-pixel PWM and a double-buffered frame store.
// Optional inter-row blanking is enabled by defining LED_SCAN_BLANK_EN.
module led_matrix_pwm_scanner #(
    parameter int unsigned ROWS    = 16,
    parameter int unsigned COLS    = 16,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned FREQDIV = 0,
    parameter int unsigned BLANK   = 1
) (
    input  logic                      Clock,
    input  logic                      RST,
    input  logic                      Enable,
    led_matrix_pwm_scanner_if.slave   frame,
    output logic                      FrameStart,
    output logic [$clog2(ROWS)-1:0]   RowOut,
    output logic [COLS-1:0]           RedOut,
    output logic [COLS-1:0]           GrnOut
);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned PW = (FREQDIV > 0) ? FREQDIV : 1;

    localparam logic [PW-1:0]    PRE_MAX    = PW'((1 << FREQDIV) - 1);
    localparam logic [DEPTH-1:0] LAST_PHASE = DEPTH'((1 << DEPTH) - 2);
    localparam logic [RW-1:0]    LAST_ROW   = RW'(ROWS - 1);

    if (ROWS < 2 || ROWS > 16 || (1 << RW) != ROWS) begin : g_bad_rows
        $error("ROWS must be a power of 2 in 2..16");
    end
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("DEPTH must be in 1..4");
    end
    if (BLANK < 1 || BLANK > 4) begin : g_bad_blank
        $error("BLANK must be in 1..4");
    end

    typedef enum logic [0:0] {StScan, StBlank} state_e;

    state_e                               state_q;
    logic [PW-1:0]                        presc_q;
    logic [RW-1:0]                        row_q;
    logic [DEPTH-1:0]                     phase_q;
    logic                                 pending_q;
    logic                                 ack_q;
    logic                                 start_q;
    logic [ROWS-1:0][COLS-1:0][DEPTH-1:0] red_q;
    logic [ROWS-1:0][COLS-1:0][DEPTH-1:0] grn_q;

    logic tick;
    logic row_end;
    logic boundary;
    logic load_now;

`ifdef LED_SCAN_BLANK_EN
    localparam logic [1:0] BLANK_LAST = 2'(BLANK - 1);
    logic [1:0] blank_q;
`endif

    assign tick = Enable && (presc_q == PRE_MAX);

    always_comb begin
`ifdef LED_SCAN_BLANK_EN
        row_end = tick && (state_q == StBlank) && (blank_q == BLANK_LAST);
`else
        row_end = tick && (state_q == StScan) && (phase_q == LAST_PHASE);
`endif
        boundary = row_end && (row_q == LAST_ROW);
        load_now = boundary && (pending_q || frame.FrameLoad);
    end

    always_ff @(posedge Clock) begin
        if (RST) begin
            state_q   <= StScan;
            presc_q   <= '0;
            row_q     <= '0;
            phase_q   <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            start_q   <= 1'b0;
            red_q     <= '0;
            grn_q     <= '0;
`ifdef LED_SCAN_BLANK_EN
            blank_q   <= '0;
`endif
        end else begin
            ack_q   <= load_now;
            start_q <= boundary;

            if (Enable) begin
                presc_q <= (presc_q == PRE_MAX) ? '0 : presc_q + 1'b1;
            end

            if (tick) begin
                unique case (state_q)
                    StScan: begin
                        if (phase_q != LAST_PHASE) begin
                            phase_q <= phase_q + 1'b1;
                        end
`ifdef LED_SCAN_BLANK_EN
                        else begin
                            state_q <= StBlank;
                            blank_q <= '0;
                        end
`endif
                    end
                    StBlank: begin
`ifdef LED_SCAN_BLANK_EN
                        if (blank_q != BLANK_LAST) begin
                            blank_q <= blank_q + 1'b1;
                        end
`endif
                    end
                    default: state_q <= StScan;
                endcase
            end

            // Row advance overrides the per-state updates above; ROWS is a power of 2 so it wraps.
            if (row_end) begin
                state_q <= StScan;
                phase_q <= '0;
                row_q   <= row_q + 1'b1;
            end

            if (load_now) begin
                red_q     <= frame.RedLevel;
                grn_q     <= frame.GrnLevel;
                pending_q <= 1'b0;
            end else if (frame.FrameLoad) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Column drive depends only on registered state, never on the incoming level arrays.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        assign RedOut[COLS-1-c] = (state_q == StScan) && (red_q[row_q][c] > phase_q);
        assign GrnOut[COLS-1-c] = (state_q == StScan) && (grn_q[row_q][c] > phase_q);
    end

    assign RowOut         = row_q;
    assign FrameStart     = start_q;
    assign frame.FrameAck = ack_q;
endmodule

// File: tb/tb_led_matrix_pwm_scanner.sv
// Randomised self-checking bench for led_matrix_pwm_scanner against a tick-count frame model.
// Follows LED_SCAN_BLANK_EN the same way as the design.
module tb_led_matrix_pwm_scanner;
    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int DEPTH   = 2;
    localparam int FREQDIV = 1;
    localparam int BLANK   = 1;
    localparam int RW      = $clog2(ROWS);
    localparam int PRE     = 1 << FREQDIV;
    localparam int NPH     = (1 << DEPTH) - 1;
`ifdef LED_SCAN_BLANK_EN
    localparam int BLANK_T = BLANK;
`else
    localparam int BLANK_T = 0;
`endif
    localparam int TPR     = NPH + BLANK_T;
    localparam int FT      = ROWS * TPR;
    localparam int W       = RW + 2 * COLS + 2;

    logic            Clock = 1'b0;
    logic            RST;
    logic            Enable;
    logic            FrameStart;
    logic [RW-1:0]   RowOut;
    logic [COLS-1:0] RedOut;
    logic [COLS-1:0] GrnOut;

    led_matrix_pwm_scanner_if #(.ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH)) frame_if ();

    led_matrix_pwm_scanner #(
        .ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH), .FREQDIV(FREQDIV), .BLANK(BLANK)
    ) dut (
        .Clock(Clock),
        .RST(RST),
        .Enable(Enable),
        .frame(frame_if),
        .FrameStart(FrameStart),
        .RowOut(RowOut),
        .RedOut(RedOut),
        .GrnOut(GrnOut)
    );

    always #5 Clock = ~Clock;

    wire [W-1:0] got = {RowOut, RedOut, GrnOut, frame_if.FrameAck, FrameStart};

    int n_checks = 0;
    int n_fail   = 0;

    // Model: enabled-cycle and tick counters fully determine scan position.
    int          n_en;
    int          n_tick;
    int          mred [ROWS][COLS];
    int          mgrn [ROWS][COLS];
    bit          mpend;
    bit          exp_ack;
    bit          exp_fs;
    logic [W-1:0] want;

    function automatic int model_pos();
        return n_tick % FT;
    endfunction

    function automatic bit next_is_boundary();
        return Enable && (n_en % PRE == PRE - 1) && ((n_tick + 1) % FT == 0);
    endfunction

    task automatic cycle();
        int pos, row, p;
        bit bnd;
        logic [COLS-1:0] er, eg;
        if (RST) begin
            n_en = 0; n_tick = 0; mpend = 0; exp_ack = 0; exp_fs = 0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin mred[r][c] = 0; mgrn[r][c] = 0; end
        end else begin
            exp_ack = 0; exp_fs = 0; bnd = 0;
            if (Enable) begin
                if (n_en % PRE == PRE - 1) begin
                    n_tick++;
                    bnd = (n_tick % FT == 0);
                end
                n_en++;
            end
            if (bnd) begin
                exp_fs = 1;
                if (mpend || frame_if.FrameLoad) begin
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++) begin
                            mred[r][c] = int'(frame_if.RedLevel[r][c]);
                            mgrn[r][c] = int'(frame_if.GrnLevel[r][c]);
                        end
                    mpend = 0;
                    exp_ack = 1;
                end
            end else if (frame_if.FrameLoad) begin
                mpend = 1;
            end
        end
        @(posedge Clock);
        #1;
        pos = model_pos(); row = pos / TPR; p = pos % TPR;
        for (int c = 0; c < COLS; c++) begin
            er[COLS-1-c] = (p < NPH) && (mred[row][c] > p);
            eg[COLS-1-c] = (p < NPH) && (mgrn[row][c] > p);
        end
        want = {RW'(row), er, eg, exp_ack, exp_fs};
    endtask

    task automatic clear_levels();
        frame_if.RedLevel = '0;
        frame_if.GrnLevel = '0;
    endtask

    task automatic rand_levels();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                frame_if.RedLevel[r][c] = DEPTH'($urandom);
                frame_if.GrnLevel[r][c] = DEPTH'($urandom);
            end
    endtask

    task automatic test_reset();
        int first = -1;
        RST = 1; Enable = 1; frame_if.FrameLoad = 0; rand_levels();
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL reset_hold: got %h want %h", got, want); end
        end
        RST = 0;
        for (int i = 1; i <= 2 * PRE * TPR; i++) begin
            cycle();
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL reset_run: got %h want %h", got, want); end
            if (first < 0 && RowOut != 0) first = i;
        end
        n_checks++;
        if (first !== PRE * TPR) begin
            n_fail++; $display("FAIL reset_first_row_change: got %0d want %0d", first, PRE * TPR);
        end
    endtask

    task automatic test_single_pixel();
        int acks = 0;
        clear_levels();
        frame_if.RedLevel[1][2] = DEPTH'(NPH);
        frame_if.FrameLoad = 1;
        cycle();
        frame_if.FrameLoad = 0;
        for (int i = 0; i < 2 * FT * PRE + 4; i++) begin
            cycle();
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL single_pixel: got %h want %h", got, want); end
            if (frame_if.FrameAck) acks++;
            if (acks > 0) rand_levels();
        end
        n_checks++;
        if (acks !== 1) begin n_fail++; $display("FAIL single_pixel_acks: got %0d want 1", acks); end
    endtask

    task automatic test_pwm();
        clear_levels();
        frame_if.GrnLevel[0][0] = DEPTH'(1);
        frame_if.GrnLevel[0][3] = DEPTH'(2);
        frame_if.FrameLoad = 1;
        cycle();
        frame_if.FrameLoad = 0;
        for (int i = 0; i < 2 * FT * PRE + 4; i++) begin
            cycle();
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL pwm: got %h want %h", got, want); end
        end
    endtask

    task automatic test_coincident();
        int guard = 0;
        while (!next_is_boundary() && guard < 2 * FT * PRE + 4) begin
            cycle(); guard++;
        end
        rand_levels();
        frame_if.FrameLoad = 1;
        cycle();
        frame_if.FrameLoad = 0;
        n_checks++;
        if (got !== want || frame_if.FrameAck !== 1'b1 || FrameStart !== 1'b1) begin
            n_fail++; $display("FAIL coincident_pulse: got %h want %h", got, want);
        end
        rand_levels();
        for (int i = 0; i < FT * PRE; i++) begin
            cycle();
            n_checks++;
            if (got !== want || frame_if.FrameAck !== 1'b0) begin
                n_fail++; $display("FAIL coincident_after: got %h want %h", got, want);
            end
        end
    endtask

    task automatic test_freeze();
        int guard = 0;
        logic [W-1:0] held;
        while (!(model_pos() / TPR == 2 && model_pos() % TPR == 1) && guard < 2 * FT * PRE) begin
            cycle(); guard++;
        end
        Enable = 0;
        held = got;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) rand_levels();
            cycle();
            n_checks++;
            if (got !== want || got[W-1:2] !== held[W-1:2]) begin
                n_fail++; $display("FAIL freeze_hold: got %h want %h", got, want);
            end
        end
        Enable = 1;
        for (int i = 0; i < FT * PRE; i++) begin
            cycle();
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL freeze_resume: got %h want %h", got, want); end
        end
    endtask

    task automatic test_rst_mid();
        int guard = 0;
        int acks = 0;
        while (model_pos() != 1 && guard < 2 * FT * PRE) begin cycle(); guard++; end
        rand_levels();
        frame_if.FrameLoad = 1;
        cycle();
        frame_if.FrameLoad = 0;
        guard = 0;
        while (model_pos() / TPR != 2 && guard < 2 * FT * PRE) begin cycle(); guard++; end
        RST = 1;
        cycle();
        n_checks++;
        if (got !== want || RowOut !== '0 || RedOut !== '0 || GrnOut !== '0) begin
            n_fail++; $display("FAIL rst_mid_state: got %h want %h", got, want);
        end
        RST = 0;
        for (int i = 0; i < 2 * FT * PRE + 4; i++) begin
            cycle();
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL rst_mid_run: got %h want %h", got, want); end
            if (frame_if.FrameAck) acks++;
        end
        n_checks++;
        if (acks !== 0) begin n_fail++; $display("FAIL rst_mid_acks: got %0d want 0", acks); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            Enable = ($urandom_range(0, 3) != 0);
            frame_if.FrameLoad = ($urandom_range(0, 15) == 0);
            rand_levels();
            cycle();
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL random: got %h want %h", got, want); end
        end
        Enable = 1;
        frame_if.FrameLoad = 0;
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_pwm();
        test_coincident();
        test_freeze();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
